// File: rtl/addr_gen_wu_wr.sv
`default_nettype none
// ============================================================================
// Module   : addr_gen_wu_wr
// Brief    : Write-side weight-update sequencer. It sweeps addresses
//            0..STOP-1 with reads and gets back each old weight and its
//            gradient RD_LAT cycles later. It writes back the saturated
//            value w - (grad >>> LR_SHIFT) to the same address.
// Revision : 1.0 - initial release
// ============================================================================
module addr_gen_wu_wr #(
    parameter int ADDR_WIDTH = 12,
    parameter int WIDTH      = 32,
    parameter int FRAC       = 24,
    parameter int STOP       = 2809,
    parameter int RD_LAT     = 2,
    parameter int LR_SHIFT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [WIDTH-1:0]      rd_data,
    input  logic [WIDTH-1:0]      grad_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(STOP - 1);

    // Weights and gradients share one fixed-point format, so FRAC never
    // enters the arithmetic; this block only documents that it is unused.
    if (FRAC >= 0) begin : g_frac_same_format
    end

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_busy;
    logic                  r_done;

    logic [RD_LAT-1:0]     r_pipe_vld;
    logic [ADDR_WIDTH-1:0] r_pipe_addr [RD_LAT];
    logic                  w_pipe_out_vld;
    logic [ADDR_WIDTH-1:0] w_pipe_out_addr;
    logic                  w_pipe_empty;

    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [WIDTH-1:0]      r_wr_data;

    logic signed [WIDTH-1:0] w_grad_sh;
    logic [WIDTH:0]          w_diff;
    logic [WIDTH-1:0]        w_sat;

    assign w_pipe_out_vld  = r_pipe_vld[RD_LAT-1];
    assign w_pipe_out_addr = r_pipe_addr[RD_LAT-1];
    assign w_pipe_empty    = ~|r_pipe_vld;

    // Next-state logic: read sweep, then drain until the last write is out.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_nxt = c_ST_READ;
            c_ST_READ:  if (r_rd_addr == c_LAST) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_pipe_empty && r_wr_en && (r_wr_addr == c_LAST))
                            w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register and read-side outputs. These are registered from the
    // next state, so the strobes line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rd_en <= (w_state_nxt == c_ST_READ);
            r_busy  <= (w_state_nxt == c_ST_READ) || (w_state_nxt == c_ST_DRAIN);
            r_done  <= (w_state_nxt == c_ST_DONE);
            if ((r_state == c_ST_IDLE) && start)
                r_rd_addr <= '0;
            else if ((r_state == c_ST_READ) && (r_rd_addr != c_LAST))
                r_rd_addr <= r_rd_addr + 1'b1;
        end
    end

    // Valid/address delay line that matches the memory read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe_addr[i] <= '0;
        end else begin
            r_pipe_vld[0]  <= r_rd_en;
            r_pipe_addr[0] <= r_rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

    // Update arithmetic: floor-shifted gradient subtracted at WIDTH+1 bits,
    // then clamped to the signed WIDTH-bit range.
    assign w_grad_sh = $signed(grad_data) >>> LR_SHIFT;
    assign w_diff    = {rd_data[WIDTH-1], rd_data} - {w_grad_sh[WIDTH-1], w_grad_sh};

    // Saturation: the top two bits disagree only on overflow.
    always_comb begin
        w_sat = w_diff[WIDTH-1:0];
        if (w_diff[WIDTH] != w_diff[WIDTH-1])
            w_sat = w_diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // Write stage: one register and a single-cycle strobe; address and
    // data hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_pipe_out_vld;
            if (w_pipe_out_vld) begin
                r_wr_addr <= w_pipe_out_addr;
                r_wr_data <= w_sat;
            end
        end
    end

    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_addr_gen_wu_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr_gen_wu_wr
// Brief    : Scoreboard bench for addr_gen_wu_wr across four configurations
//            (STOP/RD_LAT = 4/2, 1/1, 1/4, 2809/2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_addr_gen_wu_wr;

    localparam int NCFG = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a   [NCFG];
    logic        rd_en_a   [NCFG];
    logic [11:0] rd_addr_a [NCFG];
    logic        wr_en_a   [NCFG];
    logic [11:0] wr_addr_a [NCFG];
    logic [31:0] wr_data_a [NCFG];
    logic        busy_a    [NCFG];
    logic        done_a    [NCFG];

    logic [31:0] w_mem [0:4095];
    logic [31:0] g_mem [0:4095];

    logic [11:0] qa [$];
    logic [31:0] qd [$];

    int checks = 0;
    int errors = 0;
    int t0 = 0;
    int rd_cnt, wr_cnt, done_cnt, wr_first, done_rel;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int L_STOP = (gi == 0) ? 4 : (gi == 3) ? 2809 : 1;
        localparam int L_LAT  = (gi == 1) ? 1 : (gi == 2) ? 4 : 2;

        logic [31:0] rd_data;
        logic [31:0] grad_data;
        logic [3:0]  dv = '0;
        logic [11:0] da [4];

        addr_gen_wu_wr #(
            .ADDR_WIDTH(12), .WIDTH(32), .FRAC(24),
            .STOP(L_STOP), .RD_LAT(L_LAT), .LR_SHIFT(4)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_a[gi]),
            .rd_en     (rd_en_a[gi]),
            .rd_addr   (rd_addr_a[gi]),
            .rd_data   (rd_data),
            .grad_data (grad_data),
            .wr_en     (wr_en_a[gi]),
            .wr_addr   (wr_addr_a[gi]),
            .wr_data   (wr_data_a[gi]),
            .busy      (busy_a[gi]),
            .done      (done_a[gi])
        );

        // Memory model: data for a read appears L_LAT cycles after rd_en,
        // garbage otherwise.
        always @(posedge clk) begin
            dv    <= {dv[2:0], rd_en_a[gi]};
            da[0] <= rd_addr_a[gi];
            da[1] <= da[0];
            da[2] <= da[1];
            da[3] <= da[2];
        end
        assign rd_data   = dv[L_LAT-1] ? w_mem[da[L_LAT-1]] : 32'hDEAD_BEEF;
        assign grad_data = dv[L_LAT-1] ? g_mem[da[L_LAT-1]] : 32'h5555_5555;

        // Monitor: pop the scoreboard on every write, record timing.
        always @(negedge clk) begin
            if (wr_en_a[gi]) begin
                wr_cnt++;
                if (wr_first < 0) wr_first = cyc - t0;
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write cfg%0d: got addr 0x%0h with nothing expected",
                             gi, wr_addr_a[gi]);
                end else begin
                    chk($sformatf("wr_addr cfg%0d", gi), 64'(wr_addr_a[gi]), 64'(qa.pop_front()));
                    chk($sformatf("wr_data cfg%0d", gi), 64'(wr_data_a[gi]), 64'(qd.pop_front()));
                end
            end
            if (rd_en_a[gi]) rd_cnt++;
            if (done_a[gi]) begin
                done_cnt++;
                done_rel = cyc - t0;
                chk($sformatf("busy_at_done cfg%0d", gi), 64'(busy_a[gi]), 64'd0);
            end
        end
    end

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; wr_first = -1; done_rel = -1;
    endtask

    task automatic fill4(input logic [31:0] w0, g0, w1, g1, w2, g2, w3, g3);
        w_mem[0] = w0; g_mem[0] = g0; w_mem[1] = w1; g_mem[1] = g1;
        w_mem[2] = w2; g_mem[2] = g2; w_mem[3] = w3; g_mem[3] = g3;
    endtask

    task automatic expect_wr(input int a, input logic [31:0] d);
        qa.push_back(12'(a));
        qd.push_back(d);
    endtask

    // One sweep on configuration cfg; optional second start at cycle 2.
    task automatic run_sweep(input int cfg, input int stop, input int lat, input bit restart);
        int n;
        clear_stats();
        @(posedge clk); #1;
        t0 = cyc;
        start_a[cfg] = 1'b1;
        @(posedge clk); #1;
        start_a[cfg] = 1'b0;
        chk("busy_after_start", 64'(busy_a[cfg]), 64'd1);
        if (restart) begin
            @(posedge clk); #1;
            start_a[cfg] = 1'b1;
            @(posedge clk); #1;
            start_a[cfg] = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < stop + 40) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout cfg%0d: no done within %0d cycles", cfg, n);
        end
        repeat (6) @(posedge clk);
        #1;
        chk("read_count",  64'(rd_cnt),   64'(stop));
        chk("write_count", 64'(wr_cnt),   64'(stop));
        chk("done_count",  64'(done_cnt), 64'd1);
        chk("first_write_cycle", 64'(wr_first), 64'(lat + 2));
        chk("done_cycle",  64'(done_rel), 64'(stop + lat + 2));
        chk("scoreboard_empty", 64'(qa.size()), 64'd0);
        qa.delete();
        qd.delete();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < NCFG; i++) start_a[i] = 1'b0;
        clear_stats();

        // Reset state
        #1;
        chk("reset_wr", {31'd0, wr_en_a[0], wr_addr_a[0], wr_data_a[0]}, 64'd0);
        chk("reset_ctl", {rd_en_a[0], rd_addr_a[0], busy_a[0], done_a[0]}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic sweep: 0x01000000 - (0x00100000 >>> 4) = 0x00FF0000
        fill4(32'h0100_0000, 32'h0010_0000, 32'h0100_0000, 32'h0010_0000,
              32'h0100_0000, 32'h0010_0000, 32'h0100_0000, 32'h0010_0000);
        for (int k = 0; k < 4; k++) expect_wr(k, 32'h00FF_0000);
        run_sweep(0, 4, 2, 1'b0);

        // Floor shift, both saturation directions, and a small ordinary case
        fill4(32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFF0, 32'h8000_0000,
              32'h8000_0010, 32'h7FFF_FFF0, 32'h0000_0005, 32'h0000_0030);
        expect_wr(0, 32'h0000_0001);
        expect_wr(1, 32'h7FFF_FFFF);
        expect_wr(2, 32'h8000_0000);
        expect_wr(3, 32'h0000_0002);
        run_sweep(0, 4, 2, 1'b0);

        // Second start while busy is ignored
        fill4(32'h0100_0000, 32'h0010_0000, 32'h0100_0000, 32'h0010_0000,
              32'h0100_0000, 32'h0010_0000, 32'h0100_0000, 32'h0010_0000);
        for (int k = 0; k < 4; k++) expect_wr(k, 32'h00FF_0000);
        run_sweep(0, 4, 2, 1'b1);

        // Reset mid-sweep while wr_addr == 1
        for (int k = 0; k < 4; k++) expect_wr(k, 32'h00FF_0000);
        clear_stats();
        @(posedge clk); #1;
        t0 = cyc;
        start_a[0] = 1'b1;
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wr_en_a[0] && wr_addr_a[0] == 12'd1) && n < 30);
        if (n >= 30) begin
            checks++;
            errors++;
            $display("FAIL reset_trigger_timeout: wr_addr 1 never seen");
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_wr", {31'd0, wr_en_a[0], wr_addr_a[0], wr_data_a[0]}, 64'd0);
        chk("rst_mid_ctl", {rd_en_a[0], rd_addr_a[0], busy_a[0], done_a[0]}, 64'd0);
        clear_stats();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        qa.delete();
        qd.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("writes_after_rst", 64'(wr_cnt), 64'd0);
        chk("done_after_rst", 64'(done_cnt), 64'd0);
        chk("busy_after_rst", 64'(busy_a[0]), 64'd0);

        // Clean sweep after reset
        for (int k = 0; k < 4; k++) expect_wr(k, 32'h00FF_0000);
        run_sweep(0, 4, 2, 1'b0);

        // STOP=1, RD_LAT=1: 0x100 - (0x100 >>> 4) = 0xF0
        w_mem[0] = 32'h0000_0100; g_mem[0] = 32'h0000_0100;
        expect_wr(0, 32'h0000_00F0);
        run_sweep(1, 1, 1, 1'b0);

        // STOP=1, RD_LAT=4: 0x80000000 - 1 clamps to 0x80000000
        w_mem[0] = 32'h8000_0000; g_mem[0] = 32'h0000_0010;
        expect_wr(0, 32'h8000_0000);
        run_sweep(2, 1, 4, 1'b0);

        // Default STOP=2809: w[k] = k*4096, g[k] = 16 -> w[k] - 1
        for (int k = 0; k < 2809; k++) begin
            w_mem[k] = 32'(k * 4096);
            g_mem[k] = 32'd16;
            expect_wr(k, 32'(k * 4096) - 32'd1);
        end
        run_sweep(3, 2809, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
